muldiv_unit: RTL

Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage. It covers the eight M-extension operations the combinational ALU does not implement. It accepts operands with a start/ready handshake, computes the result one bit per cycle, and returns it with a one-cycle valid pulse. The control unit stalls the PC while `ready_o` is low.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [4:0]  ITER_LAST = 5'd31;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    // Operation codes equal the instruction funct3 field.
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    // Magnitude of a possibly signed operand; -2^31 maps to unsigned 0x80000000.
    function automatic logic [31:0] abs_val(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring divide.
// Multiply: {acc,lo} holds the partial product with the multiplier in lo.
// Divide:   acc is the running remainder, lo shifts the dividend out and the
//           quotient bits in.
module muldiv_step #(
    parameter int W = 32
) (
    input  logic         is_div_i,
    input  logic [W-1:0] acc_i,
    input  logic [W-1:0] lo_i,
    input  logic [W-1:0] opnd_i,
    output logic [W-1:0] acc_o,
    output logic [W-1:0] lo_o
);

    logic [W:0] sum;
    logic [W:0] shifted;
    logic [W:0] diff;

    // Compute both step kinds and select by operation class.
    always_comb begin
        sum     = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
        shifted = {acc_i, lo_i[W-1]};
        diff    = shifted - {1'b0, opnd_i};
        acc_o   = sum[W:1];
        lo_o    = {sum[0], lo_i[W-1:1]};
        if (is_div_i) begin
            if (shifted >= {1'b0, opnd_i}) begin
                acc_o = diff[W-1:0];
                lo_o  = {lo_i[W-2:0], 1'b1};
            end else begin
                acc_o = shifted[W-1:0];
                lo_o  = {lo_i[W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: IDLE -> CALC (32 cycles) -> DONE.
// Handshake: start_i is accepted only in a cycle where ready_o=1; the result is
// announced by a single-cycle valid_o pulse and result_o then holds until the
// next accepted operation completes. Starts while busy are dropped.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_num_i,
    input  logic [XLEN-1:0] b_num_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [1:0]      dbg_state_o
);

    import muldiv_pkg::*;

    muldiv_state_e   state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    muldiv_op_e      op_q, op_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] result_q, result_d;

    muldiv_op_e      op_in;
    logic            a_signed;
    logic            b_signed;
    logic            in_is_div;
    logic            in_is_rem;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_by_zero;
    logic            div_overflow;
    logic            in_neg;

    logic            op_is_div;
    logic [XLEN-1:0] step_acc;
    logic [XLEN-1:0] step_lo;
    logic [63:0]     prod_raw;
    logic [63:0]     prod_fix;
    logic [XLEN-1:0] final_result;

    // Decode the incoming request: signedness, magnitudes and special cases.
    always_comb begin
        op_in        = muldiv_op_e'(op_i);
        a_signed     = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                       (op_in == OP_DIV) || (op_in == OP_REM);
        b_signed     = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                       (op_in == OP_DIV) || (op_in == OP_REM);
        in_is_div    = op_i[2];
        in_is_rem    = op_i[2] && op_i[1];
        a_abs        = abs_val(a_num_i, a_signed);
        b_abs        = abs_val(b_num_i, b_signed);
        div_by_zero  = in_is_div && (b_num_i == '0);
        div_overflow = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                       (a_num_i == INT_MIN) && (b_num_i == DIV0_QUOT);
        in_neg       = 1'b0;
        if (!in_is_div) begin
            in_neg = (a_signed & a_num_i[XLEN-1]) ^ (b_signed & b_num_i[XLEN-1]);
        end else if (op_in == OP_DIV) begin
            in_neg = a_num_i[XLEN-1] ^ b_num_i[XLEN-1];
        end else if (op_in == OP_REM) begin
            in_neg = a_num_i[XLEN-1];
        end
    end

    assign op_is_div = op_q[2];

    muldiv_step #(.W(XLEN)) u_step (
        .is_div_i (op_is_div),
        .acc_i    (acc_q),
        .lo_i     (lo_q),
        .opnd_i   (opnd_q),
        .acc_o    (step_acc),
        .lo_o     (step_lo)
    );

    // Sign-correct the value produced by the final iteration and pick the field.
    always_comb begin
        prod_raw = {step_acc, step_lo};
        prod_fix = neg_q ? (~prod_raw + 64'd1) : prod_raw;
        case (op_q)
            OP_MUL:                       final_result = prod_fix[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod_fix[63:32];
            OP_DIV, OP_DIVU:              final_result = neg_q ? (~step_lo + 32'd1) : step_lo;
            OP_REM, OP_REMU:              final_result = neg_q ? (~step_acc + 32'd1) : step_acc;
            default:                      final_result = '0;
        endcase
    end

    // Next-state and datapath load logic for the IDLE/CALC/DONE sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d  = op_in;
                    cnt_d = 5'd0;
                    neg_d = in_neg;
                    acc_d = '0;
                    if (in_is_div) begin
                        lo_d   = a_abs;
                        opnd_d = b_abs;
                    end else begin
                        lo_d   = b_abs;
                        opnd_d = a_abs;
                    end
                    if (div_by_zero) begin
                        result_d = in_is_rem ? a_num_i : DIV0_QUOT;
                        state_d  = ST_DONE;
                    end else if (div_overflow) begin
                        result_d = in_is_rem ? '0 : INT_MIN;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = step_acc;
                lo_d  = step_lo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == ITER_LAST) begin
                    result_d = final_result;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            op_q     <= OP_MUL;
            acc_q    <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign ready_o     = (state_q == ST_IDLE);
    assign valid_o     = (state_q == ST_DONE);
    assign result_o    = result_q;
    assign dbg_state_o = state_q;

endmodule
